// File: rtl/bin2oh_wakeup_if.sv
//------------------------------------------------------------------------------
// bin2oh_wakeup_if
// Bundle of the handshake, decode and wakeup-mask signals for bin2oh_wakeup.
//
// Parameters:
//   ONE_HOT_WIDTH - number of slots (one-hot vector width)
//   BIN_WIDTH     - binary ID width
//
// Signals (names match the block's port names):
//   in_valid_i   binary ID valid                  (master -> slave)
//   in_ready_o   block can accept an ID           (slave  -> master)
//   in_bin_i     binary slot/warp ID              (master -> slave)
//   out_valid_o  registered one-hot vector valid  (slave  -> master)
//   out_ready_i  downstream accepts the vector    (master -> slave)
//   out_oh_o     registered one-hot vector        (slave  -> master)
//   pending_o    sticky wakeup mask               (slave  -> master)
//   clr_i        per-bit clear for pending_o      (master -> slave)
//   err_o        sticky out-of-range flag         (slave  -> master)
//
// Modports: slave = the decode block, master = its environment.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface bin2oh_wakeup_if #(
    parameter int unsigned ONE_HOT_WIDTH = 8,
    parameter int unsigned BIN_WIDTH     = 3
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [BIN_WIDTH-1:0]     in_bin_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [ONE_HOT_WIDTH-1:0] out_oh_o;
    logic [ONE_HOT_WIDTH-1:0] pending_o;
    logic [ONE_HOT_WIDTH-1:0] clr_i;
    logic                     err_o;

    modport slave (
        input  in_valid_i, in_bin_i, out_ready_i, clr_i,
        output in_ready_o, out_valid_o, out_oh_o, pending_o, err_o
    );

    modport master (
        output in_valid_i, in_bin_i, out_ready_i, clr_i,
        input  in_ready_o, out_valid_o, out_oh_o, pending_o, err_o
    );
endinterface

// File: rtl/bin2oh_wakeup.sv
//------------------------------------------------------------------------------
// bin2oh_wakeup
// Binary-to-one-hot decode stage with a valid/ready handshake and a sticky
// pending-wakeup mask. An accepted binary ID is decoded into a registered
// one-hot vector for downstream consumers and ORed into pending_o, which the
// scheduler clears bit-wise through clr_i. Out-of-range IDs are handshaken
// normally but decode to an all-zero vector and leave pending_o untouched.
//
// Parameters:
//   ONE_HOT_WIDTH - number of slots; 2**BIN_WIDTH must be >= ONE_HOT_WIDTH
//   BIN_WIDTH     - binary ID width
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - bin2oh_wakeup_if.slave: in_valid_i/in_ready_o/in_bin_i input
//            handshake, out_valid_o/out_ready_i/out_oh_o output handshake,
//            pending_o wakeup mask with clr_i clear, err_o range flag
//
// Build option:
//   BIN2OH_RANGE_CHK_EN - when defined, err_o goes high at the edge that
//                         accepts an out-of-range ID and stays high until
//                         reset; when undefined err_o is tied low.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module bin2oh_wakeup #(
    parameter int unsigned ONE_HOT_WIDTH = 8,
    parameter int unsigned BIN_WIDTH     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bin2oh_wakeup_if.slave   bus
);

    logic                     out_valid_q, out_valid_d;
    logic [ONE_HOT_WIDTH-1:0] out_oh_q,    out_oh_d;
    logic [ONE_HOT_WIDTH-1:0] pending_q,   pending_d;
    logic [ONE_HOT_WIDTH-1:0] dec;
    logic [ONE_HOT_WIDTH-1:0] set_vec;
    logic                     in_ready;
    logic                     accept;

    // Single register stage: a slot frees up whenever the held vector drains.
    assign in_ready = !out_valid_q || bus.out_ready_i;
    assign accept   = bus.in_valid_i && in_ready;

    // Only indices below ONE_HOT_WIDTH exist, so an out-of-range ID matches
    // no bit and naturally decodes to zero.
    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < ONE_HOT_WIDTH; i++) begin
            dec[i] = (bus.in_bin_i == i[BIN_WIDTH-1:0]);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_oh_d    = out_oh_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_oh_d    = dec;
        end else if (bus.out_ready_i) begin
            // Drain without refill; the vector keeps its last value.
            out_valid_d = 1'b0;
        end
        set_vec   = accept ? dec : '0;
        // Set is ORed in after the clear so it wins on a shared bit.
        pending_d = (pending_q & ~bus.clr_i) | set_vec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_oh_q    <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_oh_q    <= out_oh_d;
            pending_q   <= pending_d;
        end
    end

`ifdef BIN2OH_RANGE_CHK_EN
    localparam logic [BIN_WIDTH:0] OH_LIMIT = ONE_HOT_WIDTH[BIN_WIDTH:0];

    logic err_q, err_d;
    logic in_range;

    assign in_range = ({1'b0, bus.in_bin_i} < OH_LIMIT);
    assign err_d    = err_q || (accept && !in_range);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_oh_o    = out_oh_q;
    assign bus.pending_o   = pending_q;

endmodule

// File: tb/tb_bin2oh_wakeup.sv
`timescale 1ns/1ps

module tb_bin2oh_wakeup;

`ifdef BIN2OH_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Two instances share one stimulus stream: 8 slots (full range) and
    // 6 slots (IDs 6 and 7 out of range). Handshakes are identical.
    bin2oh_wakeup_if #(.ONE_HOT_WIDTH(8), .BIN_WIDTH(3)) bus8 ();
    bin2oh_wakeup_if #(.ONE_HOT_WIDTH(6), .BIN_WIDTH(3)) bus6 ();

    bin2oh_wakeup #(.ONE_HOT_WIDTH(8), .BIN_WIDTH(3)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8)
    );

    bin2oh_wakeup #(.ONE_HOT_WIDTH(6), .BIN_WIDTH(3)) dut6 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus6)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] q8[$];
    logic [5:0] q6[$];
    bit         held;
    logic [7:0] pend8;
    logic [5:0] pend6;
    bit         err6_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input int id, input int w);
        return (id < w) ? (32'd1 << id) : 32'd0;
    endfunction

    task automatic drive(input bit v, input int id, input bit ordy, input logic [7:0] clr);
        bus8.in_valid_i  = v;    bus6.in_valid_i  = v;
        bus8.in_bin_i    = id[2:0];
        bus6.in_bin_i    = id[2:0];
        bus8.out_ready_i = ordy; bus6.out_ready_i = ordy;
        bus8.clr_i       = clr;  bus6.clr_i       = clr[5:0];
    endtask

    // One clock: check state left by the previous edge, apply new inputs,
    // predict the effect of the coming edge.
    task automatic cycle(input bit v, input int id, input bit ordy, input logic [7:0] clr);
        bit exp_ready, acc;
        logic [31:0] s8, s6;
        @(posedge clk); #1;
        check("out_valid8", bus8.out_valid_o, held);
        check("out_valid6", bus6.out_valid_o, held);
        check("pending8", bus8.pending_o, pend8);
        check("pending6", bus6.pending_o, pend6);
        check("err8", bus8.err_o, 1'b0);
        check("err6", bus6.err_o, err6_m);
        drive(v, id, ordy, clr);
        #1;
        exp_ready = !held || ordy;
        check("in_ready8", bus8.in_ready_o, exp_ready);
        check("in_ready6", bus6.in_ready_o, exp_ready);
        acc = v && exp_ready;
        s8 = acc ? onehot(id, 8) : 32'd0;
        s6 = acc ? onehot(id, 6) : 32'd0;
        if (acc) begin
            q8.push_back(s8[7:0]);
            q6.push_back(s6[5:0]);
            if (id >= 6) err6_m = err6_m | RCHK;
        end
        held  = acc ? 1'b1 : (ordy ? 1'b0 : held);
        pend8 = (pend8 & ~clr) | s8[7:0];
        pend6 = (pend6 & ~clr[5:0]) | s6[5:0];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 8'h00);
        q8.delete(); q6.delete();
        held = 1'b0; pend8 = '0; pend6 = '0; err6_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid8", bus8.out_valid_o, 1'b0);
        check("rst_out_oh8", bus8.out_oh_o, 8'h00);
        check("rst_pending8", bus8.pending_o, 8'h00);
        check("rst_err6", bus6.err_o, 1'b0);
        check("rst_in_ready8", bus8.in_ready_o, 1'b1);
    endtask

    // Scoreboard monitor: front of each queue is the vector currently held.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.out_valid_o) begin
                if (q8.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mon8: out_valid with nothing expected, got %0h", bus8.out_oh_o);
                end else begin
                    check("out_oh8", bus8.out_oh_o, q8[0]);
                    if (bus8.out_ready_i) void'(q8.pop_front());
                end
            end
            if (bus6.out_valid_o) begin
                if (q6.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mon6: out_valid with nothing expected, got %0h", bus6.out_oh_o);
                end else begin
                    check("out_oh6", bus6.out_oh_o, q6[0]);
                    if (bus6.out_ready_i) void'(q6.pop_front());
                end
            end
        end
    end

    initial begin
        drive(1'b0, 0, 1'b0, 8'h00);
        held = 1'b0; pend8 = '0; pend6 = '0; err6_m = 1'b0;
        do_reset();

        // Single ID 5
        cycle(1'b1, 5, 1'b1, 8'h00);
        cycle(1'b0, 0, 1'b1, 8'h00);
        check("id5_oh", bus8.out_oh_o, 8'h20);
        check("id5_pend", bus8.pending_o, 8'h20);
        cycle(1'b0, 0, 1'b1, 8'h00);

        // Back-to-back stream 0..7
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, i, 1'b1, 8'h00);
        cycle(1'b0, 0, 1'b1, 8'h00);
        check("stream_pend8", bus8.pending_o, 8'hFF);
        check("stream_pend6", bus6.pending_o, 6'h3F);
        cycle(1'b0, 0, 1'b1, 8'hFF);

        // Backpressure: ID 3 held while ID 6 is offered
        cycle(1'b1, 3, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b1, 6, 1'b0, 8'h00);
        check("bp_hold_oh", bus8.out_oh_o, 8'h08);
        check("bp_ready", bus8.in_ready_o, 1'b0);
        cycle(1'b1, 6, 1'b1, 8'h00);
        cycle(1'b0, 0, 1'b1, 8'h00);
        check("bp_next_oh", bus8.out_oh_o, 8'h40);
        cycle(1'b0, 0, 1'b1, 8'h00);

        // Set wins over clear
        do_reset();
        cycle(1'b1, 2, 1'b1, 8'h00);
        cycle(1'b1, 3, 1'b1, 8'h00);
        cycle(1'b1, 2, 1'b1, 8'h04);
        cycle(1'b0, 0, 1'b1, 8'h0C);
        check("setwins_pend", bus8.pending_o, 8'h0C);
        cycle(1'b0, 0, 1'b1, 8'h00);
        check("clr_pend", bus8.pending_o, 8'h00);

        // Out-of-range on the 6-slot instance
        cycle(1'b1, 7, 1'b1, 8'h00);
        cycle(1'b0, 0, 1'b0, 8'h00);
        check("oor_oh6", bus6.out_oh_o, 6'h00);
        check("oor_valid6", bus6.out_valid_o, 1'b1);
        check("oor_pend6", bus6.pending_o, 6'h00);
        check("oor_err6", bus6.err_o, RCHK);
        cycle(1'b0, 0, 1'b1, 8'h00);

        // Reset while a vector is held under backpressure
        cycle(1'b1, 4, 1'b0, 8'h00);
        cycle(1'b0, 0, 1'b0, 8'h00);
        cycle(1'b0, 0, 1'b0, 8'h00);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, c);
        end

        // Drain and confirm nothing was lost
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 8'h00);
        check("drain8", q8.size(), 0);
        check("drain6", q6.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin2oh_wakeup.md
# bin2oh_wakeup

Binary-to-one-hot decode stage with a valid/ready handshake and a sticky pending mask. Completion units send a binary slot/warp ID; the block registers the matching one-hot vector for downstream consumers. It also ORs that vector into a pending-wakeup mask that the scheduler clears bit-wise. It is the inverse counterpart of the one-hot-to-binary encoder used on the issue side.

## Interface
- ONE_HOT_WIDTH, 8, number of slots / one-hot vector width
- BIN_WIDTH, 3, binary ID width; must satisfy 2**BIN_WIDTH >= ONE_HOT_WIDTH
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset, synchronous, active-high
- in_valid_i  input  1  binary ID valid
- in_ready_o  output  1  block can accept ID this cycle
- in_bin_i  input  BIN_WIDTH  binary ID
- out_valid_o  output  1  registered one-hot vector valid
- out_ready_i  input  1  downstream accepts vector
- out_oh_o  output  ONE_HOT_WIDTH  registered one-hot vector
- pending_o  output  ONE_HOT_WIDTH  sticky wakeup mask
- clr_i  input  ONE_HOT_WIDTH  per-bit clear for pending_o
- err_o  output  1  sticky out-of-range flag (see Configuration)

## Operation
- Accept: in_valid_i && in_ready_o.
- in_ready_o = !out_valid_o || out_ready_i (combinational; single-register pipeline, full throughput).
- On accept: out_oh_o <= (in_bin_i < ONE_HOT_WIDTH) ? (1 << in_bin_i) : 0; out_valid_o <= 1.
- No accept and out_ready_i && out_valid_o: out_valid_o <= 0; out_oh_o holds its last value.
- Neither: out_valid_o and out_oh_o hold. out_oh_o must not change while out_valid_o && !out_ready_i.
- Pending update each cycle: pending_o <= (pending_o & ~clr_i) | set, where set = decoded vector on accept, else 0.
- Set wins over clear for the same bit in the same cycle.
- Out-of-range ID (in_bin_i >= ONE_HOT_WIDTH, only possible when 2**BIN_WIDTH > ONE_HOT_WIDTH):
  - Still handshaken as a normal transfer.
  - out_oh_o = 0, out_valid_o = 1.
  - pending_o unchanged by the set term.
- Exactly one bit is set in out_oh_o for every in-range transfer.

## Timing
- Reset, applied at a rising edge with rst_i = 1: out_valid_o = 0, out_oh_o = 0, pending_o = 0, err_o = 0.
- in_ready_o = 1 in the first cycle after reset.
- Reset mid-transfer drops any held vector; no completion is emitted for it.
- Latency: in_bin_i accepted at edge N; out_oh_o/out_valid_o visible after edge N; pending_o bit visible after the same edge N.
- Back-to-back: with out_ready_i = 1 continuously, one ID accepted per cycle, one vector per cycle.
- Backpressure: out_ready_i = 0 with out_valid_o = 1 forces in_ready_o = 0; the held vector stays stable.
- Simultaneous drain + accept: the new vector replaces the old at the same edge; out_valid_o stays 1.
- clr_i is effective at the next edge regardless of the handshake state.

## Configuration
- BIN2OH_RANGE_CHK_EN defined:
  - err_o is set at the edge that accepts an out-of-range ID.
  - err_o stays 1 until reset.
- BIN2OH_RANGE_CHK_EN undefined:
  - err_o is tied to 0.
  - Out-of-range decode behaviour is otherwise identical: zero vector, pending unchanged.
  - No range-check logic beyond the decode compare.

## Test plan
- Reset then in_bin_i=5, valid for 1 cycle, out_ready_i=1 -> next cycle out_valid_o=1, out_oh_o=8'h20, pending_o=8'h20; following cycle out_valid_o=0.
- Stream IDs 0..7 back-to-back, out_ready_i=1 -> eight consecutive vectors 01,02,...,80; in_ready_o never drops; pending_o=8'hFF.
- Send ID 3, hold out_ready_i=0 for 4 cycles while offering ID 6 -> out_oh_o stays 8'h08, in_ready_o=0; release -> 8'h08 drains, then 8'h40 appears.
- pending_o=8'h0C, clr_i=8'h04 in the same cycle as accepting ID 2 -> pending_o=8'h0C (set wins); next cycle with clr_i=8'h0C -> pending_o=8'h00.
- ONE_HOT_WIDTH=6, BIN_WIDTH=3, ID 7 -> out_oh_o=0, out_valid_o=1, pending_o unchanged; err_o=1 with the macro, 0 without.
- Assert rst_i while a vector is held under backpressure -> next cycle out_valid_o=0, pending_o=0, err_o=0, in_ready_o=1.
